// File: rtl/line_buf_ctrl_if.sv
// Video-in / line-RAM-out signal bundle for the line buffer sequencer.
// The master drives the incoming video timing; the slave is the sequencer.
interface line_buf_ctrl_if;
    logic        pre_frame_vsync;
    logic        pre_frame_href;
    logic        pre_frame_clken;
    logic [7:0]  pre_img_data;
    logic        ram_href;
    logic        ram_clken;
    logic [7:0]  ram_shiftin;
    logic [10:0] row_idx;
    logic [9:0]  col_idx;
    logic        win_valid;
    logic        frame_done;
    logic        err_short;
    logic        err_long;
    logic        frame_abort;

    modport master (
        output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_data,
        input  ram_href, ram_clken, ram_shiftin, row_idx, col_idx,
        input  win_valid, frame_done, err_short, err_long, frame_abort
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img_data,
        output ram_href, ram_clken, ram_shiftin, row_idx, col_idx,
        output win_valid, frame_done, err_short, err_long, frame_abort
    );
endinterface

// File: rtl/line_buf_ctrl.sv
// Frame sequencer feeding the two-line shift RAM of a 3x3 window generator:
// forwards real lines, appends zero flush lines and flags complete 3-row columns.
module line_buf_ctrl #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int FLUSH_LINES = 1,
    parameter int H_GAP       = 16
) (
    input  logic            clock,
    input  logic            rst_n,
    line_buf_ctrl_if.slave  lb
);
    localparam int CW = $clog2(IMG_WIDTH + 1);
    localparam int GW = $clog2(H_GAP + 1);
    localparam logic [CW-1:0] WIDTH_C    = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_COL_C = CW'(IMG_WIDTH - 1);
    localparam logic [10:0]   LAST_ROW_C = 11'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0] GAP_LAST_C = GW'(H_GAP - 1);
    localparam logic [1:0]    FLUSH_C    = 2'(FLUSH_LINES);

    typedef enum logic [2:0] {IDLE, WAIT_LINE, LINE, FGAP, FLINE, DONE} state_t;

    state_t         state_q, state_d;
    logic           vsync_q, href_q;
    logic [CW-1:0]  col_cnt_q, col_cnt_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]     flush_q, flush_d;
    logic           long_seen_q, long_seen_d;
    logic [10:0]    row_q, row_d;
    logic [9:0]     col_idx_q, col_idx_d;
    logic           ram_href_q, ram_href_d;
    logic           ram_clken_q, ram_clken_d;
    logic [7:0]     shiftin_q, shiftin_d;
    logic           win_valid_q;
    logic           frame_done_q, frame_done_d;
    logic           err_short_q, err_short_d;
    logic           err_long_q, err_long_d;
    logic           abort_q, abort_d;

    logic vsync_rise, href_rise, href_fall, frame_active, line_cycle;

    assign vsync_rise   = lb.pre_frame_vsync & ~vsync_q;
    assign href_rise    = lb.pre_frame_href & ~href_q;
    assign href_fall    = ~lb.pre_frame_href & href_q;
    assign frame_active = (state_q == WAIT_LINE) || (state_q == LINE) ||
                          (state_q == FGAP) || (state_q == FLINE);
    // The pixel arriving with the href rise belongs to the line as well.
    assign line_cycle   = (state_q == LINE) || ((state_q == WAIT_LINE) && href_rise);

    always_comb begin
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        flush_d      = flush_q;
        long_seen_d  = long_seen_q;
        row_d        = row_q;
        col_idx_d    = col_idx_q;
        ram_href_d   = 1'b0;
        ram_clken_d  = 1'b0;
        shiftin_d    = shiftin_q;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        abort_d      = 1'b0;

        if (vsync_rise && frame_active) begin
            abort_d     = 1'b1;
            row_d       = '0;
            flush_d     = '0;
            col_cnt_d   = '0;
            long_seen_d = 1'b0;
            state_d     = WAIT_LINE;
        end else begin
            if (line_cycle) begin
                ram_href_d = lb.pre_frame_href;
                if (lb.pre_frame_href && lb.pre_frame_clken) begin
                    if (col_cnt_q < WIDTH_C) begin
                        ram_clken_d = 1'b1;
                        shiftin_d   = lb.pre_img_data;
                        col_idx_d   = 10'(col_cnt_q);
                        col_cnt_d   = col_cnt_q + CW'(1);
                    end else if (!long_seen_q) begin
                        err_long_d  = 1'b1;
                        long_seen_d = 1'b1;
                    end
                end
            end

            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (vsync_rise) begin
                        state_d     = WAIT_LINE;
                        row_d       = '0;
                        flush_d     = '0;
                        col_cnt_d   = '0;
                        long_seen_d = 1'b0;
                    end
                end
                WAIT_LINE: begin
                    if (href_rise) state_d = LINE;
                end
                LINE: begin
                    if (href_fall) begin
                        err_short_d = (col_cnt_q < WIDTH_C);
                        col_cnt_d   = '0;
                        long_seen_d = 1'b0;
                        if (row_q == LAST_ROW_C) begin
                            gap_cnt_d = '0;
                            state_d   = (FLUSH_LINES > 0) ? FGAP : DONE;
                        end else begin
                            row_d   = row_q + 11'd1;
                            state_d = WAIT_LINE;
                        end
                    end
                end
                FGAP: begin
                    if (lb.pre_frame_clken && !long_seen_q) begin
                        err_long_d  = 1'b1;
                        long_seen_d = 1'b1;
                    end
                    if (gap_cnt_q == GAP_LAST_C) begin
                        gap_cnt_d = '0;
                        col_cnt_d = '0;
                        row_d     = row_q + 11'd1;
                        state_d   = FLINE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
                FLINE: begin
                    ram_href_d  = 1'b1;
                    ram_clken_d = 1'b1;
                    shiftin_d   = 8'd0;
                    col_idx_d   = 10'(col_cnt_q);
                    if (col_cnt_q == LAST_COL_C) begin
                        col_cnt_d = '0;
                        flush_d   = flush_q + 2'd1;
                        if (flush_q + 2'd1 == FLUSH_C) begin
                            state_d = DONE;
                        end else begin
                            gap_cnt_d   = '0;
                            long_seen_d = 1'b0;
                            state_d     = FGAP;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            col_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            flush_q      <= '0;
            long_seen_q  <= 1'b0;
            row_q        <= '0;
            col_idx_q    <= '0;
            ram_href_q   <= 1'b0;
            ram_clken_q  <= 1'b0;
            shiftin_q    <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= lb.pre_frame_vsync;
            href_q       <= lb.pre_frame_href;
            col_cnt_q    <= col_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            flush_q      <= flush_d;
            long_seen_q  <= long_seen_d;
            row_q        <= row_d;
            col_idx_q    <= col_idx_d;
            ram_href_q   <= ram_href_d;
            ram_clken_q  <= ram_clken_d;
            shiftin_q    <= shiftin_d;
            // Tracks the RAM's one-cycle read latency; row_q still belongs to that pixel.
            win_valid_q  <= ram_clken_q && (row_q >= 11'd2);
            frame_done_q <= frame_done_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            abort_q      <= abort_d;
        end
    end

    assign lb.ram_href    = ram_href_q;
    assign lb.ram_clken   = ram_clken_q;
    assign lb.ram_shiftin = shiftin_q;
    assign lb.row_idx     = row_q;
    assign lb.col_idx     = col_idx_q;
    assign lb.win_valid   = win_valid_q;
    assign lb.frame_done  = frame_done_q;
    assign lb.err_short   = err_short_q;
    assign lb.err_long    = err_long_q;
    assign lb.frame_abort = abort_q;
endmodule
